// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - streaming sequencer around the 8-bit shift-add multiplier
// Queues operand pairs, runs one multiply at a time, presents products on valid/ready.
module mul_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int MUL_LAT = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mul_load,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_data,
    output logic               busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPTURE
    } state_t;

    state_t             state_q, state_d;
    logic [NW-1:0]      cnt_q, cnt_d;
    logic               mul_load_q, mul_load_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] out_data_q, out_data_d;

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    logic               push;
    logic               pop;
    logic [2*WIDTH-1:0] head;

    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];

    // Entry format is {a, b}; storage needs no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_load_d  = mul_load_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        pop         = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && (!out_valid_q || out_ready)) begin
                    pop     = 1'b1;
                    mul_a_d = head[2*WIDTH-1:WIDTH];
                    mul_b_d = head[WIDTH-1:0];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                mul_load_d = 1'b1;
                cnt_d      = '0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + NW'(1);
                if (cnt_q == NW'(MUL_LAT - 1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                out_data_d  = mul_result;
                out_valid_d = 1'b1;
                mul_load_d  = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mul_load_q  <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_load_q  <= mul_load_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign mul_load  = mul_load_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - directed and random checks of mul_seq_ctrl with a shift-add multiplier model
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, mul_load, out_valid, out_ready, busy;
    logic [7:0]  in_a, in_b, mul_a, mul_b;
    logic [15:0] mul_result, out_data;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.WIDTH(8), .DEPTH(4), .MUL_LAT(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    // Multiplier stage: load low initialises, 8 load-high edges iterate, 9th writes result.
    logic [15:0] m_a, m_acc;
    logic [7:0]  m_b;
    int          m_it;
    always @(posedge clk) begin
        if (!mul_load) begin
            m_a   <= {8'd0, mul_a};
            m_b   <= mul_b;
            m_acc <= '0;
            m_it  <= 0;
        end else if (m_it < 8) begin
            if (m_b[m_it[2:0]]) m_acc <= m_acc + (m_a << m_it);
            m_it <= m_it + 1;
        end else if (m_it == 8) begin
            mul_result <= m_acc;
            m_it       <= 9;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0, n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          got_cyc[$];
    logic        hold_q = 1'b0;
    logic [15:0] hold_data_q = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Handshakes seen here complete at the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ov_while_load", {31'd0, out_valid & mul_load}, 32'd0);
            if (hold_q) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {16'd0, out_data}, {16'd0, hold_data_q});
            end
            hold_q      <= out_valid && !out_ready;
            hold_data_q <= out_data;
            if (in_valid && in_ready) exp_q.push_back(16'(in_a) * 16'(in_b));
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_cyc.push_back(cyc + 1);
                if (exp_q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
                else                   chk("scoreboard", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
            end
        end else begin
            hold_q <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [7:0] a, input logic [7:0] b);
        int g;
        in_a = a; in_b = b; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin tick(); g++; end
        if (g >= 100) chk("push_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n, input int budget);
        int g;
        g = 0;
        while (got_q.size() < n && g < budget) begin tick(); g++; end
        if (got_q.size() < n) chk("wait_timeout", got_q.size(), n);
    endtask

    logic [7:0]  fa [6] = '{8'd3, 8'd10, 8'd255, 8'd16, 8'd100, 8'd200};
    logic [7:0]  fb [6] = '{8'd5, 8'd20, 8'd1,   8'd16, 8'd100, 8'd3};
    logic [15:0] fexp [6] = '{16'd15, 16'd200, 16'd255, 16'd256, 16'd10000, 16'd600};
    logic [15:0] bexp [4] = '{16'd0, 16'd65025, 16'd1, 16'd256};
    int   e, g, k, lowcnt, sent;
    logic fire;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mul_load", mul_load, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // single op
        out_ready = 1'b1; got_q.delete(); got_cyc.delete();
        in_a = 8'd13; in_b = 8'd11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        e = cyc; lowcnt = 0; g = 0;
        while (!out_valid && g < 40) begin
            if (!mul_load) lowcnt++;
            tick(); g++;
        end
        chk("single_latency", cyc - e, 12);
        chk("single_data", out_data, 143);
        chk("single_load_low", lowcnt, 2);
        chk("single_mul_a", mul_a, 13);
        chk("single_mul_b", mul_b, 11);
        tick();
        chk("single_ov_one_cycle", out_valid, 0);
        chk("single_busy", busy, 0);
        chk("single_count", got_q.size(), 1);

        // boundary operands back to back
        got_q.delete(); got_cyc.delete();
        push1(8'd0, 8'd200); push1(8'd255, 8'd255); push1(8'd1, 8'd1); push1(8'd128, 8'd2);
        wait_outs(4, 100);
        for (int i = 0; i < 4; i++)
            if (got_q.size() > i) chk("bnd_data", got_q[i], bexp[i]);
        for (int i = 1; i < 4; i++)
            if (got_cyc.size() > i) chk("bnd_spacing", got_cyc[i] - got_cyc[i-1], 12);
        repeat (2) tick();

        // FIFO fill under backpressure
        out_ready = 1'b0; got_q.delete(); k = 0;
        for (int i = 0; i < 40; i++) begin
            if (k < 6) begin in_a = fa[k]; in_b = fb[k]; in_valid = 1'b1; end
            else in_valid = 1'b0;
            fire = in_valid && in_ready;
            tick();
            if (fire) k++;
        end
        chk("full_accepted", k, 5);
        chk("full_in_ready", in_ready, 0);
        chk("full_busy", busy, 1);
        chk("full_out_valid", out_valid, 1);
        chk("full_out_data", out_data, 15);
        out_ready = 1'b1; g = 0;
        while ((k < 6 || got_q.size() < 6) && g < 200) begin
            if (k < 6) begin in_a = fa[k]; in_b = fb[k]; in_valid = 1'b1; end
            else in_valid = 1'b0;
            fire = in_valid && in_ready;
            tick();
            if (fire) k++;
            g++;
        end
        in_valid = 1'b0;
        chk("full_total", got_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (got_q.size() > i) chk("full_data", got_q[i], fexp[i]);
        repeat (2) tick();

        // output backpressure for 30 cycles
        out_ready = 1'b0; got_q.delete();
        push1(8'd9, 8'd9); push1(8'd6, 8'd7);
        g = 0;
        while (!out_valid && g < 40) begin tick(); g++; end
        repeat (30) tick();
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, 81);
        chk("bp_no_pop_a", mul_a, 9);
        chk("bp_no_pop_b", mul_b, 9);
        out_ready = 1'b1;
        tick();
        chk("bp_pop_a", mul_a, 6);
        chk("bp_pop_b", mul_b, 7);
        chk("bp_ov_clear", out_valid, 0);
        chk("bp_load_low", mul_load, 0);
        wait_outs(2, 40);
        if (got_q.size() > 1) chk("bp_second", got_q[1], 42);
        repeat (2) tick();

        // reset in the middle of RUN with two entries queued
        got_q.delete();
        push1(8'd50, 8'd3); push1(8'd2, 8'd2); push1(8'd4, 8'd4);
        repeat (4) tick();
        chk("pre_rst_running", mul_load, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("midrst_no_output", got_q.size(), 0);
        push1(8'd7, 8'd9);
        wait_outs(1, 40);
        if (got_q.size() > 0) chk("post_rst_data", got_q[0], 63);
        repeat (2) tick();

        // random traffic
        got_q.delete(); sent = 0; g = 0;
        while (sent < 500 && g < 30000) begin
            if (!in_valid && $urandom_range(9) < 7) begin
                in_a = 8'($urandom); in_b = 8'($urandom); in_valid = 1'b1;
            end
            out_ready = ($urandom_range(9) < 6);
            fire = in_valid && in_ready;
            tick();
            if (fire) begin sent++; in_valid = 1'b0; end
            g++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_outs(500, 400);
        tick();
        chk("rand_sent", sent, 500);
        chk("rand_outputs", got_q.size(), 500);
        chk("rand_busy_drained", busy, 0);
        chk("rand_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
